recfg_lane_engine: RTL and testbench

//  Parametrised streaming successor to the 16x16 reconfigurable array.

---
 rtl/recfg_pkg.sv | 22 ++
 rtl/recfg_sat_shift.sv | 42 ++++
 rtl/recfg_lane_engine.sv | 144 ++++++++++++++
 tb/tb_recfg_lane_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recfg_pkg.sv
// recfg_pkg: shared types and helpers for the reconfigurable lane engine.
package recfg_pkg;

  typedef enum logic [1:0] {
    MODE_MAC   = 2'b00,
    MODE_EWM   = 2'b01,
    MODE_SCALE = 2'b10,
    MODE_RSVD  = 2'b11
  } recfg_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_e;

  // Width of a beat counter able to hold 0..max_k.
  function automatic int recfg_kw(input int max_k);
    return $clog2(max_k + 1);
  endfunction

endpackage

// File: rtl/recfg_sat_shift.sv
// recfg_sat_shift: per-lane ACC_WIDTH -> DATA_WIDTH arithmetic shift with saturation.
// Build macro RECFG_ROUND_EN: add half an LSB before the shift (round half up).
module recfg_sat_shift #(
  parameter int ACC_WIDTH  = 40,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 0
) (
  input  logic signed [ACC_WIDTH-1:0]  v,
  output logic        [DATA_WIDTH-1:0] q,
  output logic                         sat
);

  // One guard bit so the rounding bias can never wrap the accumulator.
  localparam int EW = ACC_WIDTH + 1;
  localparam logic signed [EW-1:0] MAXV = {{(EW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`ifdef RECFG_ROUND_EN
  localparam int RSH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [EW-1:0] RND = (FRAC_BITS > 0) ? (EW'(1) << RSH) : {EW{1'b0}};
`else
  localparam logic signed [EW-1:0] RND = {EW{1'b0}};
`endif

  logic signed [EW-1:0] ext, biased, shifted;

  // Bias, shift, then clamp into the signed output range.
  always_comb begin
    ext     = {v[ACC_WIDTH-1], v};
    biased  = ext + RND;
    shifted = biased >>> FRAC_BITS;
    sat     = 1'b0;
    q       = shifted[DATA_WIDTH-1:0];
    if (shifted > MAXV) begin
      q   = MAXV[DATA_WIDTH-1:0];
      sat = 1'b1;
    end else if (shifted < MINV) begin
      q   = MINV[DATA_WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/recfg_lane_engine.sv
// recfg_lane_engine: LANES-wide streaming GEMV column-accumulate / element-wise
// multiply / scalar scale engine with valid/ready beats and saturating output.
// Build macro RECFG_ROUND_EN (in recfg_sat_shift): round half up before the shift.
module recfg_lane_engine
  import recfg_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC_BITS  = 0,
  parameter int MAX_K      = 256,
  parameter int KW         = recfg_kw(MAX_K)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_start,
  input  logic [1:0]                          cfg_mode,
  input  logic [KW-1:0]                       cfg_k_len,
  input  logic                                cfg_acc_en,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]    acc_in_vec,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]    a_vec,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]    b_vec,
  input  logic [DATA_WIDTH-1:0]               b_scalar,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    out_vec,
  output logic                                busy,
  output logic                                done,
  output logic                                sat_flag,
  output logic                                cfg_err
);

  state_e      state, state_nxt;
  recfg_mode_e mode;
  logic [KW-1:0] k_len, beat_cnt;
  logic cfg_bad, start_ok, beat_fire, out_fire, last_beat;
  logic [LANES-1:0][DATA_WIDTH-1:0] lane_q;
  logic [LANES-1:0]                 lane_sat;

  assign cfg_bad   = (cfg_k_len == '0) || (cfg_k_len > KW'(MAX_K)) || (cfg_mode == MODE_RSVD);
  assign start_ok  = (state == IDLE) && cfg_start && !cfg_bad;
  assign beat_fire = (state == RUN) && in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_beat = (beat_cnt == k_len - KW'(1));
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and input back-pressure.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = RUN;
      RUN: begin
        in_ready = (mode == MODE_MAC) ? 1'b1 : (!out_valid || out_ready);
        if (in_valid && in_ready && last_beat) state_nxt = DRAIN;
      end
      DRAIN: if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DATA_WIDTH-1:0]   op_x, op_y;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext, sum, acc;

    // Operand select; MAC feeds the running sum, EWM/SCALE the bare product.
    always_comb begin
      op_x     = (mode == MODE_SCALE) ? b_vec[g] : a_vec[g];
      op_y     = (mode == MODE_EWM)   ? b_vec[g] : b_scalar;
      prod     = (2*DATA_WIDTH)'(op_x) * (2*DATA_WIDTH)'(op_y);
      prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
      sum      = (mode == MODE_MAC) ? acc + prod_ext : prod_ext;
    end

    // Accumulator: seeded on a MAC start, wraps at ACC_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        acc <= '0;
      else if (start_ok && cfg_mode == MODE_MAC)
        acc <= cfg_acc_en ? {{(ACC_WIDTH-DATA_WIDTH){acc_in_vec[g][DATA_WIDTH-1]}}, acc_in_vec[g]} : '0;
      else if (beat_fire && mode == MODE_MAC)
        acc <= sum;
    end

    recfg_sat_shift #(
      .ACC_WIDTH (ACC_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_sat (
      .v  (sum),
      .q  (lane_q[g]),
      .sat(lane_sat[g])
    );
  end

  // Job config, beat count, output register and status pulses.
  // The last MAC beat saturates the freshly summed value directly, so the
  // result is registered on that beat and out_valid rises the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= MODE_MAC;
      k_len     <= '0;
      beat_cnt  <= '0;
      out_vec   <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (state == IDLE && cfg_start) begin
        if (cfg_bad) begin
          cfg_err <= 1'b1;
        end else begin
          mode     <= recfg_mode_e'(cfg_mode);
          k_len    <= cfg_k_len;
          beat_cnt <= '0;
          sat_flag <= 1'b0;
        end
      end
      if (out_fire) out_valid <= 1'b0;
      if (beat_fire) begin
        beat_cnt <= beat_cnt + KW'(1);
        if (mode != MODE_MAC || last_beat) begin
          out_vec   <= lane_q;
          out_valid <= 1'b1;
          sat_flag  <= sat_flag | (|lane_sat);
        end
      end
      if (state == DRAIN && out_fire) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_recfg_lane_engine.sv
// tb_recfg_lane_engine: table vectors, stall/reset/config corner sequences and
// randomized jobs checked against an arithmetic reference model.
module tb_recfg_lane_engine;

  localparam int LANES = 16;
  localparam int DW    = 16;
  localparam int MAX_K = 256;
  localparam int KW    = $clog2(MAX_K + 1);
  localparam int FL    = 4;
  localparam logic [1:0] M_MAC = 2'd0, M_EWM = 2'd1, M_SCALE = 2'd2;

  typedef logic [LANES-1:0][DW-1:0] vec_t;
  typedef logic [FL-1:0][DW-1:0]    fvec_t;
  typedef struct {
    logic [1:0] mode;
    int k;
    bit acc_en;
    bit seed_idx;
    int a;
    int b;
    int bs;
    int seed;
    int exp;
    bit exp_sat;
  } tv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cfg_start, cfg_acc_en, in_valid, in_ready, out_valid, out_ready;
  logic busy, done, sat_flag, cfg_err;
  logic [1:0] cfg_mode;
  logic [KW-1:0] cfg_k_len;
  logic [DW-1:0] b_scalar;
  vec_t acc_in_vec, a_vec, b_vec, out_vec;

  logic f_cfg_start, f_cfg_acc_en, f_in_valid, f_in_ready, f_out_valid, f_out_ready;
  logic f_busy, f_done, f_sat_flag, f_cfg_err;
  logic [1:0] f_cfg_mode;
  logic [KW-1:0] f_cfg_k_len;
  logic [DW-1:0] f_b_scalar;
  fvec_t f_acc_in_vec, f_a_vec, f_b_vec, f_out_vec;

  recfg_lane_engine u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_k_len(cfg_k_len), .cfg_acc_en(cfg_acc_en), .acc_in_vec(acc_in_vec),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .b_scalar(b_scalar), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .busy(busy), .done(done), .sat_flag(sat_flag), .cfg_err(cfg_err)
  );

  recfg_lane_engine #(.LANES(FL), .FRAC_BITS(4)) u_frac (
    .clk(clk), .rst_n(rst_n), .cfg_start(f_cfg_start), .cfg_mode(f_cfg_mode),
    .cfg_k_len(f_cfg_k_len), .cfg_acc_en(f_cfg_acc_en), .acc_in_vec(f_acc_in_vec),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .a_vec(f_a_vec), .b_vec(f_b_vec),
    .b_scalar(f_b_scalar), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_vec(f_out_vec), .busy(f_busy), .done(f_done), .sat_flag(f_sat_flag), .cfg_err(f_cfg_err)
  );

  int checks = 0;
  int errors = 0;
  int beat_a[MAX_K][LANES];
  int beat_b[MAX_K][LANES];
  int beat_bs[MAX_K];
  int seed[LANES];
  vec_t exp_q[$];
  bit exp_sat;
  tv_t tbl[8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: optional half-LSB bias, floor shift, clamp to signed DW range.
  function automatic longint ref_out(input longint v, input int frac, output bit s);
    longint t;
    t = v;
`ifdef RECFG_ROUND_EN
    if (frac > 0) t = t + (longint'(1) <<< (frac - 1));
`endif
    t = t >>> frac;
    s = 1'b0;
    if (t > 32767) begin t = 32767; s = 1'b1; end
    else if (t < -32768) begin t = -32768; s = 1'b1; end
    return t;
  endfunction

  function automatic longint wrap40(input longint v);
    return (v <<< 24) >>> 24;
  endfunction

  function automatic int rnd16();
    logic signed [15:0] r;
    case ($urandom_range(0, 7))
      0: return 32767;
      1: return -32768;
      2: return int'($urandom_range(0, 15)) - 8;
      default: begin r = 16'($urandom); return int'(r); end
    endcase
  endfunction

  task automatic load_entry(input int n);
    vec_t e;
    for (int b = 0; b < tbl[n].k; b++) begin
      beat_bs[b] = tbl[n].bs;
      for (int i = 0; i < LANES; i++) begin
        beat_a[b][i] = tbl[n].a;
        beat_b[b][i] = tbl[n].b;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      seed[i] = tbl[n].seed_idx ? i : tbl[n].seed;
      e[i] = 16'(tbl[n].exp + (tbl[n].seed_idx ? i : 0));
    end
    exp_q.delete();
    for (int b = 0; b < ((tbl[n].mode == M_MAC) ? 1 : tbl[n].k); b++) exp_q.push_back(e);
    exp_sat = tbl[n].exp_sat;
  endtask

  task automatic build_random(output logic [1:0] mode, output int k, output bit acc_en);
    longint acc, t;
    bit s;
    vec_t e;
    mode   = 2'($urandom_range(0, 2));
    k      = $urandom_range(1, 8);
    acc_en = 1'($urandom_range(0, 1));
    for (int i = 0; i < LANES; i++) seed[i] = rnd16();
    for (int b = 0; b < k; b++) begin
      beat_bs[b] = rnd16();
      for (int i = 0; i < LANES; i++) begin
        beat_a[b][i] = rnd16();
        beat_b[b][i] = rnd16();
      end
    end
    exp_q.delete();
    exp_sat = 1'b0;
    if (mode == M_MAC) begin
      for (int i = 0; i < LANES; i++) begin
        acc = acc_en ? longint'(seed[i]) : 0;
        for (int b = 0; b < k; b++) acc = wrap40(acc + longint'(beat_a[b][i]) * beat_bs[b]);
        t = ref_out(acc, 0, s);
        e[i] = 16'(t);
        exp_sat |= s;
      end
      exp_q.push_back(e);
    end else begin
      for (int b = 0; b < k; b++) begin
        for (int i = 0; i < LANES; i++) begin
          if (mode == M_EWM) t = ref_out(longint'(beat_a[b][i]) * beat_b[b][i], 0, s);
          else               t = ref_out(longint'(beat_bs[b]) * beat_b[b][i], 0, s);
          e[i] = 16'(t);
          exp_sat |= s;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  // stall: 0 none, 1 random valid/ready gaps and stray starts, 2 hold out_ready low 5 cycles.
  task automatic run_job(input logic [1:0] mode, input int k, input bit acc_en, input int stall);
    int beat, got, dones, errs, stall_cnt, cyc, nexp, budget;
    bit hold, exp_ov;
    vec_t held;
    nexp = exp_q.size();
    budget = 64 + 8 * k;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_mode = mode; cfg_k_len = KW'(k); cfg_acc_en = acc_en;
    for (int i = 0; i < LANES; i++) acc_in_vec[i] = 16'(seed[i]);
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_mode = 2'b11; cfg_k_len = '0;
    chk("busy_after_start", busy, 1);
    beat = 0; got = 0; dones = 0; errs = 0; stall_cnt = 0; cyc = 0;
    hold = 1'b0; exp_ov = 1'b0; held = '0;
    while (!(got >= nexp && dones > 0) && cyc < budget) begin
      in_valid = (beat < k) && (stall != 1 || $urandom_range(0, 3) != 0);
      for (int i = 0; i < LANES; i++) begin
        a_vec[i] = in_valid ? 16'(beat_a[beat][i]) : 16'($urandom);
        b_vec[i] = in_valid ? 16'(beat_b[beat][i]) : 16'($urandom);
      end
      b_scalar = in_valid ? 16'(beat_bs[beat]) : 16'($urandom);
      if (stall == 1)
        out_ready = ($urandom_range(0, 2) != 0);
      else if (stall == 2 && out_valid && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else
        out_ready = 1'b1;
      cfg_start = (stall == 1) && (got < nexp) && ($urandom_range(0, 7) == 0);
      #1;
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk_vec("hold_vec", out_vec, held);
      end
      if (exp_ov) chk("result_latency", out_valid, 1);
      if (mode != M_MAC && out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (done) begin
        dones++;
        chk("done_after_last", got, nexp);
      end
      if (cfg_err) errs++;
      if (out_valid && out_ready) begin
        if (got < nexp) chk_vec("out_vec", out_vec, exp_q[got]);
        got++;
      end
      hold = out_valid && !out_ready;
      held = out_vec;
      exp_ov = in_valid && in_ready && (mode != M_MAC || beat == k - 1);
      if (in_valid && in_ready) beat++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; cfg_start = 1'b0; out_ready = 1'b0;
    chk("out_count", got, nexp);
    chk("beats_taken", beat, k);
    chk("done_count", dones, 1);
    chk("stray_cfg_err", errs, 0);
    chk("sat_flag", sat_flag, exp_sat);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    logic [1:0] rm;
    int rk, dn;
    bit ra, s;
    fvec_t fexp;
    int fb[FL];

    tbl[0] = '{M_MAC,   4,     1'b0, 1'b0, 3,      0,      2,      0, 24,     1'b0};
    tbl[1] = '{M_MAC,   1,     1'b1, 1'b1, 1,      0,      -5,     0, -5,     1'b0};
    tbl[2] = '{M_MAC,   2,     1'b0, 1'b0, 32767,  0,      32767,  0, 32767,  1'b1};
    tbl[3] = '{M_MAC,   2,     1'b0, 1'b0, 32767,  0,      -32768, 0, -32768, 1'b1};
    tbl[4] = '{M_EWM,   2,     1'b0, 1'b0, -300,   7,      0,      0, -2100,  1'b0};
    tbl[5] = '{M_SCALE, 3,     1'b0, 1'b0, 0,      -32768, -32768, 0, 32767,  1'b1};
    tbl[6] = '{M_MAC,   MAX_K, 1'b1, 1'b0, 1,      0,      1,      -7, 249,   1'b0};
    tbl[7] = '{M_EWM,   1,     1'b0, 1'b0, -32768, 1,      0,      0, -32768, 1'b0};

    rst_n = 1'b0; cfg_start = 1'b0; cfg_mode = '0; cfg_k_len = '0; cfg_acc_en = 1'b0;
    acc_in_vec = '0; in_valid = 1'b0; a_vec = '0; b_vec = '0; b_scalar = '0; out_ready = 1'b0;
    f_cfg_start = 1'b0; f_cfg_mode = '0; f_cfg_k_len = '0; f_cfg_acc_en = 1'b0;
    f_acc_in_vec = '0; f_in_valid = 1'b0; f_a_vec = '0; f_b_vec = '0; f_b_scalar = '0;
    f_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk_vec("rst_out_vec", out_vec, '0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;

    for (int n = 0; n < 8; n++) begin
      load_entry(n);
      run_job(tbl[n].mode, tbl[n].k, tbl[n].acc_en, 0);
    end

    // EWM with 5-cycle consumer stall after the first result.
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < LANES; i++) begin
        beat_a[b][i] = i;
        beat_b[b][i] = 2;
      end
    beat_bs[0] = 0; beat_bs[1] = 0; beat_bs[2] = 0;
    begin
      vec_t e;
      for (int i = 0; i < LANES; i++) e[i] = 16'(2 * i);
      exp_q.delete();
      repeat (3) exp_q.push_back(e);
    end
    exp_sat = 1'b0;
    run_job(M_EWM, 3, 1'b0, 2);

    // Fractional instance: SCALE k=1, b_scalar=24.
    fb[0] = 1; fb[1] = -1; fb[2] = 3; fb[3] = -3;
    @(posedge clk); #1;
    f_cfg_start = 1'b1; f_cfg_mode = M_SCALE; f_cfg_k_len = KW'(1);
    @(posedge clk); #1;
    f_cfg_start = 1'b0; f_in_valid = 1'b1; f_b_scalar = 16'(24); f_out_ready = 1'b1;
    for (int i = 0; i < FL; i++) f_b_vec[i] = 16'(fb[i]);
    @(posedge clk); #1;
    f_in_valid = 1'b0;
    for (int i = 0; i < FL; i++) fexp[i] = 16'(ref_out(longint'(24 * fb[i]), 4, s));
    chk("frac_valid", f_out_valid, 1);
    for (int i = 0; i < FL; i++) chk($sformatf("frac_lane%0d", i), longint'($signed(f_out_vec[i])), longint'($signed(fexp[i])));
    chk("frac_sat", f_sat_flag, 0);
    @(posedge clk); #1;
    chk("frac_done", f_done, 1);
    chk("frac_busy", f_busy, 0);
    f_out_ready = 1'b0;

    // Reset after two of four MAC beats.
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_mode = M_MAC; cfg_k_len = KW'(4); cfg_acc_en = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; b_scalar = 16'(2);
    for (int i = 0; i < LANES; i++) a_vec[i] = 16'(3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk_vec("mid_rst_vec", out_vec, '0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dn = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) dn++;
    end
    chk("post_rst_quiet", dn, 0);
    load_entry(0);
    run_job(tbl[0].mode, tbl[0].k, tbl[0].acc_en, 0);

    // Invalid starts: k=0, k>MAX_K, reserved mode.
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      cfg_start = 1'b1;
      cfg_mode  = (n == 2) ? 2'b11 : M_MAC;
      cfg_k_len = (n == 0) ? KW'(0) : ((n == 1) ? KW'(MAX_K + 1) : KW'(4));
      @(posedge clk); #1;
      cfg_start = 1'b0;
      chk($sformatf("cfg_err_pulse%0d", n), cfg_err, 1);
      chk($sformatf("cfg_err_busy%0d", n), busy, 0);
      @(posedge clk); #1;
      chk($sformatf("cfg_err_clear%0d", n), cfg_err, 0);
    end

    for (int r = 0; r < 40; r++) begin
      build_random(rm, rk, ra);
      run_job(rm, rk, ra, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
